// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin arbiter that merges NUM_REQ producer streams into one sync_fifo write port.
// Optional ARB_STATS_EN macro adds per-requester beat counters and a stall counter.
module fifo_rr_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 1024,
  parameter int BURST_MAX  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [$clog2(DATA_DEPTH):0]   fifo_cnt,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef ARB_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [NUM_REQ*16-1:0]         stat_beats,
  output logic [15:0]                   stat_stall
`endif
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(DATA_DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                r_state;
  logic [GW-1:0]         r_rr_ptr;
  logic [GW-1:0]         r_grant_id;
  logic [BW-1:0]         r_beat_cnt;
  logic                  r_wr_en;
  logic [DATA_WIDTH-1:0] r_data;

  state_t                w_state_nxt;
  logic [GW-1:0]         w_rr_ptr_nxt;
  logic [GW-1:0]         w_grant_nxt;
  logic [BW-1:0]         w_beat_nxt;
  logic                  w_wr_en_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt;

  logic [GW-1:0]         w_pick;
  logic [GW-1:0]         w_idx;
  logic                  w_any_valid;
  logic [SW-1:0]         w_space_sum;
  logic                  w_space_ok;
  logic                  w_grant_valid;
  logic                  w_grant_last;
  logic [DATA_WIDTH-1:0] w_grant_data;
  logic                  w_accept;
  logic                  w_cap_hit;

  // The registered write is not yet visible in fifo_cnt, so it is counted as occupied.
  assign w_space_sum = SW'(fifo_cnt) + SW'(r_wr_en);
  assign w_space_ok  = (w_space_sum < SW'(DATA_DEPTH));

  assign w_grant_valid = req_valid[r_grant_id];
  assign w_grant_last  = req_last[r_grant_id];
  assign w_grant_data  = req_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign w_cap_hit     = (r_beat_cnt == BW'(BURST_MAX - 1));

  // Handshake: a beat transfers on a cycle where req_valid[i] and req_ready[i] are both high;
  // req_ready is only ever raised for the grantee during BURST and only while the FIFO has room.
  assign w_accept = (r_state == BURST) && w_grant_valid && w_space_ok;

  always_comb begin
    req_ready = '0;
    if (r_state == BURST) req_ready[r_grant_id] = w_space_ok;
  end

  // Highest offset first so the lowest offset from rr_ptr+1 wins.
  always_comb begin
    w_pick      = r_rr_ptr;
    w_idx       = '0;
    w_any_valid = |req_valid;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = GW'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (req_valid[w_idx]) w_pick = w_idx;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_grant_nxt  = r_grant_id;
    w_beat_nxt   = r_beat_cnt;
    w_wr_en_nxt  = 1'b0;
    w_data_nxt   = r_data;
    case (r_state)
      IDLE: begin
        if (w_any_valid) begin
          w_grant_nxt = w_pick;
          w_beat_nxt  = '0;
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        if (w_accept) begin
          w_wr_en_nxt = 1'b1;
          w_data_nxt  = w_grant_data;
          w_beat_nxt  = r_beat_cnt + BW'(1);
          if (w_grant_last || w_cap_hit) begin
            w_state_nxt  = IDLE;
            w_rr_ptr_nxt = r_grant_id;
          end
        end else if (!w_grant_valid) begin
          w_state_nxt  = IDLE;
          w_rr_ptr_nxt = r_grant_id;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= GW'(NUM_REQ - 1);
      r_grant_id <= '0;
      r_beat_cnt <= '0;
      r_wr_en    <= 1'b0;
      r_data     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_grant_id <= w_grant_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_data     <= w_data_nxt;
    end
  end

  assign fifo_wr_en   = r_wr_en;
  assign fifo_data_in = r_data;
  assign grant_id     = r_grant_id;
  assign busy         = (r_state == BURST);

`ifdef ARB_STATS_EN
  logic [15:0] r_stat_beats [NUM_REQ];
  logic [15:0] r_stat_stall;
  logic        w_stall;

  assign w_stall = (r_state == BURST) && w_grant_valid && !w_space_ok;

  // A clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      for (int i = 0; i < NUM_REQ; i++) r_stat_beats[i] <= '0;
      r_stat_stall <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept && (r_grant_id == GW'(i)) && (r_stat_beats[i] != 16'hFFFF))
          r_stat_beats[i] <= r_stat_beats[i] + 16'd1;
      end
      if (w_stall && (r_stat_stall != 16'hFFFF)) r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_beats[g*16 +: 16] = r_stat_beats[g];
  end
  assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Bench for fifo_rr_wr_arbiter: transaction-level reference model, expected-write queue and monitor.
`timescale 1ns/1ps
module tb_fifo_rr_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int D  = 1024;
  localparam int BM = 8;
  localparam int CW = $clog2(D) + 1;
  localparam int GW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last  = '0;
  logic [N*W-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic [CW-1:0]  fifo_cnt  = '0;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_data_in;
  logic [GW-1:0]  grant_id;
  logic           busy;
`ifdef ARB_STATS_EN
  logic           stat_clr = 1'b0;
  logic [N*16-1:0] stat_beats;
  logic [15:0]    stat_stall;
`endif

  fifo_rr_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .DATA_DEPTH(D), .BURST_MAX(BM)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .fifo_cnt(fifo_cnt), .fifo_wr_en(fifo_wr_en),
    .fifo_data_in(fifo_data_in), .grant_id(grant_id), .busy(busy)
`ifdef ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_beats(stat_beats), .stat_stall(stat_stall)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  int wr_ids[$];
  bit armed = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Arbitration described as "who owns the port, how many beats so far, who went last".
  bit           m_busy = 1'b0;
  int           m_gid  = 0;
  int           m_ptr  = N - 1;
  int           m_beats = 0;
  bit           m_wr   = 1'b0;
  bit           m_acc [N];
  bit           m_space;
  bit           m_stall;
  bit           m_found;
  logic [N-1:0] m_ready;
  int           ms_beats [N];
  int           ms_stall = 0;

  always @(negedge clk) begin
    if (armed) begin
      m_space = (int'(fifo_cnt) + (m_wr ? 1 : 0)) < D;
      m_ready = '0;
      if (m_busy) m_ready[m_gid] = m_space;
      check("busy", 64'(busy), 64'(m_busy));
      check("grant_id", 64'(grant_id), 64'(m_gid));
      check("req_ready", 64'(req_ready), 64'(m_ready));
`ifdef ARB_STATS_EN
      for (int i = 0; i < N; i++) check($sformatf("stat_beats%0d", i), 64'(stat_beats[i*16 +: 16]), 64'(ms_beats[i]));
      check("stat_stall", 64'(stat_stall), 64'(ms_stall));
`endif
      m_stall = m_busy && req_valid[m_gid] && !m_space;
      for (int i = 0; i < N; i++) m_acc[i] = 1'b0;
      if (rst) begin
        m_busy = 1'b0; m_gid = 0; m_ptr = N - 1; m_beats = 0; m_wr = 1'b0;
      end else if (!m_busy) begin
        m_wr = 1'b0;
        m_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          if (!m_found && req_valid[(m_ptr + k) % N]) begin
            m_gid = (m_ptr + k) % N;
            m_found = 1'b1;
          end
        end
        if (m_found) begin
          m_busy = 1'b1;
          m_beats = 0;
        end
      end else if (req_valid[m_gid] && m_space) begin
        exp_q.push_back(req_data[m_gid*W +: W]);
        m_acc[m_gid] = 1'b1;
        m_beats++;
        m_wr = 1'b1;
        if (req_last[m_gid] || m_beats == BM) begin
          m_busy = 1'b0;
          m_ptr = m_gid;
        end
      end else begin
        m_wr = 1'b0;
        if (!req_valid[m_gid]) begin
          m_busy = 1'b0;
          m_ptr = m_gid;
        end
      end
`ifdef ARB_STATS_EN
      if (rst || stat_clr) begin
        for (int i = 0; i < N; i++) ms_beats[i] = 0;
        ms_stall = 0;
      end else begin
        for (int i = 0; i < N; i++) if (m_acc[i] && ms_beats[i] < 65535) ms_beats[i]++;
        if (m_stall && ms_stall < 65535) ms_stall++;
      end
`endif
    end
  end

  // ---------------- monitor ----------------
  logic [W-1:0] mon_exp;
  bit           mon_want;
  always @(posedge clk) begin
    #1;
    if (armed) begin
      mon_want = (exp_q.size() != 0);
      check("fifo_wr_en", 64'(fifo_wr_en), 64'(mon_want));
      if (mon_want) begin
        mon_exp = exp_q.pop_front();
        if (fifo_wr_en === 1'b1) begin
          check("fifo_data_in", 64'(fifo_data_in), 64'(mon_exp));
          wr_ids.push_back(int'(fifo_data_in[31:24]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  int seq [N];

  task automatic refresh_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = {8'(i), 24'(seq[i])};
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) if (m_acc[i]) seq[i]++;
    refresh_data();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_last = '0;
    fifo_cnt = '0;
    tick();
    armed = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic int count_id(input int id);
    int c = 0;
    foreach (wr_ids[i]) if (wr_ids[i] == id) c++;
    return c;
  endfunction

  int rr_exp [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    for (int i = 0; i < N; i++) begin
      seq[i] = 0;
      m_acc[i] = 1'b0;
      ms_beats[i] = 0;
    end
    refresh_data();
    tick();
    do_reset();
    check("reset_wr_en", 64'(fifo_wr_en), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ready", 64'(req_ready), 64'd0);

    // Round-robin fairness: everyone valid, single-beat packets.
    wr_ids.delete();
    req_valid = 4'b1111; req_last = 4'b1111;
    repeat (14) tick();
    check("rr_writes", 64'(wr_ids.size() >= 6), 64'd1);
    if (wr_ids.size() >= 6)
      for (int i = 0; i < 6; i++) check($sformatf("rr_order%0d", i), 64'(wr_ids[i]), 64'(rr_exp[i]));

    // Burst cap: requester 2 streams without last while requester 0 waits.
    do_reset();
    wr_ids.delete();
    req_valid = 4'b0100; req_last = '0;
    tick();
    req_valid = 4'b0101;
    repeat (11) tick();
    check("cap_beats_req2", 64'(count_id(2)), 64'd8);
    check("cap_writes", 64'(wr_ids.size() >= 9), 64'd1);
    if (wr_ids.size() >= 9) check("cap_next_req0", 64'(wr_ids[8]), 64'd0);
    req_valid = '0;
    repeat (2) tick();

    // Full boundary.
    do_reset();
    req_valid = 4'b0001; req_last = '0; fifo_cnt = CW'(1023);
    tick();
    tick();
    check("full_wr_en", 64'(fifo_wr_en), 64'd1);
    check("full_ready_pending", 64'(req_ready), 64'd0);
    fifo_cnt = CW'(1024);
    tick();
    check("full_ready_1024", 64'(req_ready), 64'd0);
    tick();
    check("full_still_busy", 64'(busy), 64'd1);
    fifo_cnt = CW'(1023);
    #1;
    check("full_ready_back", 64'(req_ready), 64'd1);
    tick();
    check("full_resume_wr", 64'(fifo_wr_en), 64'd1);
    req_valid = '0; fifo_cnt = '0;
    repeat (2) tick();

    // Valid drop: requester 3 releases after two beats.
    do_reset();
    wr_ids.delete();
    req_valid = 4'b1000; req_last = '0;
    repeat (3) tick();
    req_valid = 4'b0011;
    repeat (2) tick();
    check("drop_grant", 64'(grant_id), 64'd0);
    check("drop_busy", 64'(busy), 64'd1);
    check("drop_beats_req3", 64'(count_id(3)), 64'd2);
    req_valid = '0;
    repeat (3) tick();

    // Reset mid-burst.
    do_reset();
    wr_ids.delete();
    req_valid = 4'b0010; req_last = '0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_wr_en", 64'(fifo_wr_en), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_grant", 64'(grant_id), 64'd0);
    check("rstmid_beats", 64'(count_id(1)), 64'd3);
    req_valid = 4'b0011;
    tick();
    check("rstmid_first_grant", 64'(grant_id), 64'd0);
    req_valid = '0;
    repeat (3) tick();

`ifdef ARB_STATS_EN
    do_reset();
    req_valid = 4'b0010; req_last = '0;
    repeat (6) tick();
    fifo_cnt = CW'(1024);
    repeat (2) tick();
    check("stat_beats1_pre", 64'(stat_beats[16 +: 16]), 64'd5);
    check("stat_stall_pre", 64'(stat_stall), 64'd2);
    fifo_cnt = '0; stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("stat_beats1_clr", 64'(stat_beats[16 +: 16]), 64'd0);
    check("stat_stall_clr", 64'(stat_stall), 64'd0);
    req_valid = '0;
    repeat (3) tick();
`endif

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_last[i]  = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 4) == 0) fifo_cnt = CW'($urandom_range(1020, 1024));
      else fifo_cnt = CW'($urandom_range(0, 900));
      rst = ($urandom_range(0, 199) == 0);
`ifdef ARB_STATS_EN
      stat_clr = ($urandom_range(0, 99) == 0);
`endif
      tick();
    end
    rst = 1'b0;
    req_valid = '0;
    fifo_cnt = '0;
`ifdef ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (4) tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_rr_wr_arbiter.md
Name: fifo_rr_wr_arbiter

Overview:
Round-robin write arbiter that shares one sync_fifo write port among NUM_REQ producers, e.g. NPU PE-row result streams merging into a single writeback FIFO.
- Grants one requester at a time for a burst of up to BURST_MAX beats.
- Drives the FIFO write port with registered signals.
- Uses fifo_cnt for flow control, so the FIFO is never written while full.

Parameters:
NUM_REQ, 4, number of requesters (>=2).
DATA_WIDTH, 32, beat width; matches sync_fifo DATA_WIDTH.
DATA_DEPTH, 1024, FIFO depth; matches sync_fifo DATA_DEPTH.
BURST_MAX, 8, maximum beats per grant (>=1).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous active-high reset.
req_valid  in  NUM_REQ  per-requester beat valid.
req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
req_last  in  NUM_REQ  marks the final beat of a requester's packet.
req_ready  out  NUM_REQ  per-requester beat accept; combinational.
fifo_cnt  in  $clog2(DATA_DEPTH)+1  occupancy from sync_fifo.
fifo_wr_en  out  1  registered write enable to sync_fifo.
fifo_data_in  out  DATA_WIDTH  registered write data to sync_fifo.
grant_id  out  $clog2(NUM_REQ)  index of the current or last grantee.
busy  out  1  high while in BURST.

Behaviour:
Reset:
- Applies on any clk edge with rst=1, including mid-burst; no beat is written after that edge.
- Reset values: state=IDLE, fifo_wr_en=0, fifo_data_in=0, grant_id=0, busy=0, req_ready=0, beat_cnt=0, rr_ptr=NUM_REQ-1 (so requester 0 wins first).

Space check:
- space_ok = (fifo_cnt + fifo_wr_en) < DATA_DEPTH, computed at width $clog2(DATA_DEPTH)+2 to avoid overflow.
- fifo_wr_en counts the registered write not yet reflected in fifo_cnt.
- Concurrent reads only add space, so the check is conservative.

States:
- IDLE:
  - req_ready=0.
  - If any req_valid is high, pick the first valid index searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - Latch it into grant_id, clear beat_cnt, go to BURST.
  - If none is valid, stay in IDLE.
- BURST:
  - req_ready[grant_id] = space_ok; all other req_ready bits = 0.
  - A beat is accepted when req_valid[grant_id] & req_ready[grant_id].
  - On an accepted beat, at the next edge: fifo_wr_en=1, fifo_data_in = that requester's data (1-cycle latency), beat_cnt += 1.
  - If no beat is accepted, fifo_wr_en=0 next cycle.

Burst exit (BURST to IDLE, with rr_ptr<=grant_id), on any of:
- an accepted beat with req_last=1;
- an accepted beat with beat_cnt==BURST_MAX-1;
- req_valid[grant_id]=0 for that cycle (grantee released, no beat written).

Other rules:
- Stalling on space_ok=0 does not end the burst. The burst waits until space returns.
- Every exit passes through IDLE, so there is one arbitration bubble per grant.
- Back-to-back grants to the same requester occur only when no other req_valid is high.
- Data of a non-granted requester is never sampled.
- Beat order within a requester is preserved. Beats from different requesters are never interleaved inside one burst.

Optional Feature:
ARB_STATS_EN
- Defined adds:
  - input stat_clr (1);
  - output stat_beats (NUM_REQ*16): one 16-bit counter per requester, +1 per accepted beat, saturating at 16'hFFFF;
  - output stat_stall (16): +1 per BURST cycle with req_valid[grant_id]=1 and space_ok=0, saturating.
- All counters clear on rst or stat_clr. stat_clr takes priority over an increment in the same cycle.
- Undefined: these ports and the logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-burst:
  - Stimulus: req 1 in BURST with 3 beats accepted, rst pulsed 1 cycle.
  - Required: next cycle fifo_wr_en=0, busy=0, grant_id=0; no further beats written; next arbitration grants requester 0 first if valid.
- Round-robin fairness:
  - Stimulus: all 4 req_valid held high, every beat req_last=1.
  - Required: grant sequence 0,1,2,3,0,1 with one IDLE bubble between grants; FIFO receives one beat per grant in that order.
- Burst cap:
  - Stimulus: req 2 streams 20 beats with req_last never set, req 0 also valid.
  - Required: req 2 writes exactly 8 beats, then req 0 is granted.
- Full boundary:
  - Stimulus: fifo_cnt driven to 1023 with fifo_wr_en=0, one beat accepted.
  - Required: next cycle fifo_wr_en=1 and req_ready=0; with fifo_cnt=1024, req_ready stays 0.
  - Then drop fifo_cnt to 1023 with fifo_wr_en=0: req_ready=1 that cycle and the burst resumes.
- Valid drop:
  - Stimulus: req 3 granted, req_valid[3] deasserted after 2 beats.
  - Required: burst ends with 2 writes, rr_ptr=3, next grant goes to the lowest valid index above 3 (wrapping).
- Stats (ARB_STATS_EN):
  - Stimulus: 5 beats from req 1, 2 stall cycles, then stat_clr concurrent with a beat.
  - Required: stat_beats[1]=5 and stat_stall=2 before the clear; both read 0 after the clear.
